// File: rtl/sq_acc_sender_if.sv
// Bundle of FIFO-write, burst-control and accumulator-feed signals for sq_acc_sender.
interface sq_acc_sender_if;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       start;
  logic [3:0] burst_len;
  logic [1:0] gap;
  logic [7:0] a;
  logic       valid;
  logic       full;
  logic       empty;
  logic       busy;
  logic       done;

  modport slave (
    input  wr_data, wr_en, start, burst_len, gap,
    output a, valid, full, empty, busy, done
  );

  modport master (
    output wr_data, wr_en, start, burst_len, gap,
    input  a, valid, full, empty, busy, done
  );
endinterface

// File: rtl/sq_acc_sender.sv
// 8-deep sample FIFO feeding a sum-of-squares accumulator in bursts,
// with an optional programmable idle gap between beats.
module sq_acc_sender (
  input  logic             clk,
  input  logic             reset,
  sq_acc_sender_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t     state;
  logic [7:0] mem [8];
  logic [2:0] wptr, rptr;
  logic [3:0] count;
  logic [3:0] remaining;
  logic [1:0] gap_cfg, gcnt;
  logic       push, pop;

  // Pop sees only the registered count, so a fresh push is poppable next edge.
  assign push = bus.wr_en && (count != 4'd8);
  assign pop  = (state == SEND) && (count != 4'd0);

  assign bus.full  = (count == 4'd8);
  assign bus.empty = (count == 4'd0);
  assign bus.busy  = (state != IDLE);

  always_ff @(posedge clk)
    if (push) mem[wptr] <= bus.wr_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 3'd1;
      if (pop)  rptr <= rptr + 3'd1;
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bus.a     <= '0;
      bus.valid <= 1'b0;
      bus.done  <= 1'b0;
      remaining <= '0;
      gap_cfg   <= '0;
      gcnt      <= '0;
    end else begin
      bus.a     <= '0;
      bus.valid <= 1'b0;
      bus.done  <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          remaining <= bus.burst_len;
          gap_cfg   <= bus.gap;
          state     <= (bus.burst_len == 4'd0) ? DONE : SEND;
        end
        SEND: if (pop) begin
          bus.a     <= mem[rptr];
          bus.valid <= 1'b1;
          remaining <= remaining - 4'd1;
          // No gap after the final beat: done follows it directly.
          if (remaining == 4'd1)     state <= DONE;
          else if (gap_cfg != 2'd0) begin
            gcnt  <= gap_cfg;
            state <= GAP;
          end
        end
        GAP: begin
          if (gcnt == 2'd1) state <= SEND;
          gcnt <= gcnt - 2'd1;
        end
        DONE: begin
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sq_acc_sender.sv
// Directed, table-driven bench for sq_acc_sender plus hand-written corner sequences.
module tb_sq_acc_sender;
  logic clk;
  logic reset;
  sq_acc_sender_if bus();

  sq_acc_sender dut (.clk(clk), .reset(reset), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       st;
    logic [3:0] bl;
    logic [1:0] gp;
    logic       v;
    logic [7:0] a;
    logic       d;
    logic       b;
    logic       f;
    logic       e;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(logic we, logic [7:0] wd, logic st, logic [3:0] bl, logic [1:0] gp,
                              logic v, logic [7:0] a, logic d, logic b, logic f, logic e);
    vec_t r;
    r.we = we; r.wd = wd; r.st = st; r.bl = bl; r.gp = gp;
    r.v = v; r.a = a; r.d = d; r.b = b; r.f = f; r.e = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [7:0] wd, input logic st,
                       input logic [3:0] bl, input logic [1:0] gp);
    bus.wr_en = we; bus.wr_data = wd; bus.start = st; bus.burst_len = bl; bus.gap = gp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_tick();
    drive(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic push(input logic [7:0] d);
    drive(1, d, 0, 0, 0);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [7:0] a,
                         input logic d, input logic b);
    chk({name, ".valid"}, 32'(bus.valid), 32'(v));
    chk({name, ".a"},     32'(bus.a),     32'(a));
    chk({name, ".done"},  32'(bus.done),  32'(d));
    chk({name, ".busy"},  32'(bus.busy),  32'(b));
  endtask

  int acc;

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    #2;
    chk("rst.valid", 32'(bus.valid), 0);
    chk("rst.a",     32'(bus.a), 0);
    chk("rst.done",  32'(bus.done), 0);
    chk("rst.busy",  32'(bus.busy), 0);
    chk("rst.empty", 32'(bus.empty), 1);
    chk("rst.full",  32'(bus.full), 0);
    @(negedge clk);
    reset = 1'b1;

    //            we wd  st bl gp   v  a  d  b  f  e
    tbl[0]  = mk(1, 21, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 36, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0,  1, 2, 0,   0, 0, 0, 1, 0, 0);
    tbl[3]  = mk(0, 0,  0, 0, 0,   1, 21,0, 1, 0, 0);
    tbl[4]  = mk(0, 0,  0, 0, 0,   1, 36,0, 1, 0, 1);
    tbl[5]  = mk(0, 0,  0, 0, 0,   0, 0, 1, 0, 0, 1);
    tbl[6]  = mk(0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 1);
    // gap=2 burst
    tbl[7]  = mk(1, 10, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 20, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0,  1, 2, 2,   0, 0, 0, 1, 0, 0);
    tbl[10] = mk(0, 0,  0, 0, 0,   1, 10,0, 1, 0, 0);
    tbl[11] = mk(0, 0,  0, 0, 0,   0, 0, 0, 1, 0, 0);
    tbl[12] = mk(0, 0,  0, 0, 0,   0, 0, 0, 1, 0, 0);
    tbl[13] = mk(0, 0,  0, 0, 0,   1, 20,0, 1, 0, 1);
    tbl[14] = mk(0, 0,  0, 0, 0,   0, 0, 1, 0, 0, 1);
    // burst_len=0
    tbl[15] = mk(0, 0,  1, 0, 0,   0, 0, 0, 1, 0, 1);
    tbl[16] = mk(0, 0,  0, 0, 0,   0, 0, 1, 0, 0, 1);
    tbl[17] = mk(0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 1);
    // start pulsed while busy is ignored
    tbl[18] = mk(1, 1,  0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[19] = mk(1, 2,  0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[20] = mk(1, 3,  0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[21] = mk(0, 0,  1, 2, 0,   0, 0, 0, 1, 0, 0);
    tbl[22] = mk(0, 0,  1, 5, 3,   1, 1, 0, 1, 0, 0);
    tbl[23] = mk(0, 0,  1, 5, 3,   1, 2, 0, 1, 0, 0);
    tbl[24] = mk(0, 0,  0, 0, 0,   0, 0, 1, 0, 0, 0);
    tbl[25] = mk(0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0);

    acc = 0;
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].we, tbl[i].wd, tbl[i].st, tbl[i].bl, tbl[i].gp);
      tick();
      chk($sformatf("vec%0d", i), {27'd0, bus.valid, bus.done, bus.busy, bus.full, bus.empty},
          {27'd0, tbl[i].v, tbl[i].d, tbl[i].b, tbl[i].f, tbl[i].e});
      chk($sformatf("vec%0d.a", i), 32'(bus.a), 32'(tbl[i].a));
      if (i <= 5 && bus.valid) acc += int'(bus.a) * int'(bus.a);
      if (i == 5) chk("acc_f", acc, 1737);
    end

    // underflow stall: beats follow their pushes by one cycle
    do_reset();
    push(5);
    drive(0, 0, 1, 3, 0); tick();
    chk_out("uf.start", 0, 0, 0, 1);
    idle_tick(); chk_out("uf.b1", 1, 5, 0, 1);
    idle_tick(); chk_out("uf.stall0", 0, 0, 0, 1);
    idle_tick(); chk_out("uf.stall1", 0, 0, 0, 1);
    push(6);     chk_out("uf.push6", 0, 0, 0, 1);
    idle_tick(); chk_out("uf.b2", 1, 6, 0, 1);
    idle_tick(); chk_out("uf.stall2", 0, 0, 0, 1);
    push(7);     chk_out("uf.push7", 0, 0, 0, 1);
    idle_tick(); chk_out("uf.b3", 1, 7, 0, 1);
    idle_tick(); chk_out("uf.done", 0, 0, 1, 0);

    // fill to full, drop the 9th, drain in order
    do_reset();
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk("full.after8", 32'(bus.full), 1);
    push(9);
    chk("full.after9", 32'(bus.full), 1);
    drive(0, 0, 1, 8, 0); tick();
    for (int i = 1; i <= 8; i++) begin
      idle_tick();
      chk_out($sformatf("drain%0d", i), 1, 8'(i), 0, 1);
    end
    chk("drain.empty", 32'(bus.empty), 1);
    idle_tick(); chk_out("drain.done", 0, 0, 1, 0);

    // asynchronous reset mid-burst
    do_reset();
    for (int i = 1; i <= 4; i++) push(8'(i));
    drive(0, 0, 1, 4, 0); tick();
    idle_tick(); chk_out("ar.b1", 1, 1, 0, 1);
    idle_tick(); chk_out("ar.b2", 1, 2, 0, 1);
    #2 reset = 1'b0;
    #1;
    chk_out("ar.async", 0, 0, 0, 0);
    chk("ar.empty", 32'(bus.empty), 1);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 1, 1, 0); tick();
    chk_out("ar.restart", 0, 0, 0, 1);
    idle_tick(); chk_out("ar.stall0", 0, 0, 0, 1);
    idle_tick(); chk_out("ar.stall1", 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
